// File: rtl/uart_word_tx.sv
// uart_word_tx -- transmit side of the UART word link.
// Sends a DATA_WIDTH-bit word as DATA_WIDTH/8 back-to-back 8N1 frames.
// Ports:
//   Clk        system clock (rising edge)
//   Rst        synchronous, active-high reset
//   data       word to send, sampled on the accept cycle only
//   send_en    start request, accepted only while idle
//   Baud_Set   rate select: 0=9600 1=19200 2=38400 3=57600 4..7=115200
//   uart_tx    serial line, idle high, driven straight from a flop
//   Tx_Done    one-cycle pulse after the final stop bit of the word
//   uart_state 1 while a word is in flight
module uart_word_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned CLK_HZ     = 50_000_000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  send_en,
  input  logic [2:0]            Baud_Set,
  output logic                  uart_tx,
  output logic                  Tx_Done,
  output logic                  uart_state
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CNT_W = $clog2(CLK_HZ / 9600 + 1);

  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_HZ / 9600);
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_HZ / 19200);
  localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_HZ / 38400);
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_HZ / 57600);
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_HZ / 115200);
  localparam logic [BI_W-1:0]  LAST_IDX   = BI_W'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        div_q, div_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [BI_W-1:0]         byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        div_sel;
  logic                    tick;
  logic [7:0]              byte_d;

  always_comb begin
    case (Baud_Set)
      3'd0:    div_sel = DIV_9600;
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      default: div_sel = DIV_115200;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    done_d     = 1'b0;

    tick = (cnt_q == div_q - CNT_W'(1));
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (send_en) begin
          word_d     = data;
          div_d      = div_sel;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (byte_idx_q != LAST_IDX) begin
            // Shift the next byte into the transmit slot; the start bit
            // follows the stop bit with no idle gap.
            byte_idx_d = byte_idx_q + BI_W'(1);
            word_d     = MSB_FIRST ? (word_q << 8) : (word_q >> 8);
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is computed from the next state so uart_tx is a plain flop.
    byte_d = MSB_FIRST ? word_d[DATA_WIDTH-1 -: 8] : word_d[7:0];
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx    = tx_q;
  assign Tx_Done    = done_q;
  assign uart_state = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx -- directed self-checking bench for uart_word_tx.
// Four instances: 8-bit and two 32-bit (LSB/MSB byte order) at 50 MHz,
// plus an 8-bit one at 5 MHz for the baud sweep.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data;
  logic [2:0]  baud;
  logic [3:0]  send;
  logic [3:0]  tx, done, busy;

  uart_word_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .CLK_HZ(50_000_000)) u_w8 (
    .Clk(clk), .Rst(rst), .data(data[7:0]), .send_en(send[0]), .Baud_Set(baud),
    .uart_tx(tx[0]), .Tx_Done(done[0]), .uart_state(busy[0]));

  uart_word_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b0), .CLK_HZ(50_000_000)) u_w32l (
    .Clk(clk), .Rst(rst), .data(data), .send_en(send[1]), .Baud_Set(baud),
    .uart_tx(tx[1]), .Tx_Done(done[1]), .uart_state(busy[1]));

  uart_word_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .CLK_HZ(50_000_000)) u_w32m (
    .Clk(clk), .Rst(rst), .data(data), .send_en(send[2]), .Baud_Set(baud),
    .uart_tx(tx[2]), .Tx_Done(done[2]), .uart_state(busy[2]));

  uart_word_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .CLK_HZ(5_000_000)) u_w8s (
    .Clk(clk), .Rst(rst), .data(data[7:0]), .send_en(send[3]), .Baud_Set(baud),
    .uart_tx(tx[3]), .Tx_Done(done[3]), .uart_state(busy[3]));

  logic [1:0] sel;
  logic       mon_tx, mon_done, mon_busy;
  always_comb begin
    mon_tx   = tx[sel];
    mon_done = done[sel];
    mon_busy = busy[sel];
  end

  // Tx_Done pulse counters, one per instance.
  int unsigned dcnt [4] = '{0, 0, 0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) dcnt[i] <= dcnt[i] + 32'(done[i]);
  end

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // 8N1 frame, bit 0 = start bit.
  function automatic logic [9:0] frm(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Called at the first sampled cycle of a start bit. Samples the first and
  // last cycle of every bit period; returns at the cycle after the stop bit.
  task automatic rx_frame(input int unsigned div, output logic [9:0] lo,
                          output logic [9:0] hi, output logic busy_all);
    busy_all = 1'b1;
    lo = '0;
    hi = '0;
    for (int k = 0; k < 10; k++) begin
      lo[k] = mon_tx;
      busy_all &= mon_busy;
      repeat (div - 1) @(negedge clk);
      hi[k] = mon_tx;
      busy_all &= mon_busy;
      @(negedge clk);
    end
  endtask

  task automatic pulse_send(input int idx);
    send[idx] = 1'b1;
    @(negedge clk);
    send[idx] = 1'b0;
  endtask

  task automatic run32(input logic [1:0] idx, input logic [31:0] seq, input string nm);
    logic [9:0]  lo, hi;
    logic        b;
    logic [7:0]  eb;
    int unsigned d0;
    sel = idx;
    data = 32'h1234_5678;
    baud = 3'd4;
    d0 = dcnt[idx];
    pulse_send(idx);
    check({nm, "_start"}, 32'(mon_tx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      eb = seq[31 - 8*i -: 8];
      rx_frame(434, lo, hi, b);
      check($sformatf("%s_b%0d_lo", nm, i), 32'(lo), 32'(frm(eb)));
      check($sformatf("%s_b%0d_hi", nm, i), 32'(hi), 32'(frm(eb)));
      check($sformatf("%s_b%0d_busy", nm, i), 32'(b), 32'd1);
    end
    check({nm, "_done"}, 32'(mon_done), 32'd1);
    check({nm, "_idle"}, 32'(mon_busy), 32'd0);
    @(negedge clk);
    check({nm, "_ndone"}, dcnt[idx] - d0, 32'd1);
  endtask

  initial begin
    logic [9:0]  lo, hi;
    logic        b;
    int unsigned d0, c;
    int unsigned exp_div [8] = '{520, 260, 130, 86, 43, 43, 43, 43};

    rst = 1'b1; send = '0; data = '0; baud = 3'd4; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'hF);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte 0x55 at 115200
    sel = 2'd0; data = 32'h55; baud = 3'd4; d0 = dcnt[0];
    pulse_send(0);
    check("t1_start", 32'(mon_tx), 32'd0);
    check("t1_busy0", 32'(mon_busy), 32'd1);
    rx_frame(434, lo, hi, b);
    check("t1_lo", 32'(lo), 32'(frm(8'h55)));
    check("t1_hi", 32'(hi), 32'(frm(8'h55)));
    check("t1_busy", 32'(b), 32'd1);
    check("t1_done", 32'(mon_done), 32'd1);
    check("t1_idle", 32'(mon_busy), 32'd0);
    check("t1_txhi", 32'(mon_tx), 32'd1);
    @(negedge clk);
    check("t1_done_clr", 32'(mon_done), 32'd0);
    check("t1_ndone", dcnt[0] - d0, 32'd1);

    // 2/3: 32-bit word, both byte orders
    run32(2'd1, 32'h7856_3412, "t2");
    run32(2'd2, 32'h1234_5678, "t3");

    // 4: mid-frame request/baud change ignored, then back-to-back word
    sel = 2'd0; data = 32'hA5; baud = 3'd4; d0 = dcnt[0];
    pulse_send(0);
    check("t4_start", 32'(mon_tx), 32'd0);
    fork
      begin
        repeat (1000) @(negedge clk);
        data = 32'h3C; baud = 3'd0; send[0] = 1'b1;
        @(negedge clk);
        send[0] = 1'b0;
        repeat (500) @(negedge clk);
        baud = 3'd4;
      end
      rx_frame(434, lo, hi, b);
    join
    check("t4_a5_lo", 32'(lo), 32'(frm(8'hA5)));
    check("t4_a5_hi", 32'(hi), 32'(frm(8'hA5)));
    check("t4_done1", 32'(mon_done), 32'd1);
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    check("t4_b2b_start", 32'(mon_tx), 32'd0);
    check("t4_b2b_busy", 32'(mon_busy), 32'd1);
    rx_frame(434, lo, hi, b);
    check("t4_3c_lo", 32'(lo), 32'(frm(8'h3C)));
    check("t4_3c_hi", 32'(hi), 32'(frm(8'h3C)));
    check("t4_done2", 32'(mon_done), 32'd1);
    @(negedge clk);
    check("t4_ndone", dcnt[0] - d0, 32'd2);

    // 5: baud sweep on the 5 MHz instance, data 0x00 -> 9 low bit periods
    sel = 2'd3; data = '0;
    for (int bs = 0; bs < 8; bs++) begin
      baud = 3'(bs);
      pulse_send(3);
      c = 0;
      while (mon_tx == 1'b0 && c < 20000) begin
        c++;
        @(negedge clk);
      end
      check($sformatf("t5_low_b%0d", bs), c, 9 * exp_div[bs]);
      c = 0;
      while (mon_done == 1'b0 && c < 20000) begin
        c++;
        @(negedge clk);
      end
      check($sformatf("t5_stop_b%0d", bs), c, exp_div[bs]);
      @(negedge clk);
    end

    // 6: reset during data bit 3 of 0xFF aborts the word
    sel = 2'd0; data = 32'hFF; baud = 3'd4; d0 = dcnt[0];
    pulse_send(0);
    repeat (4 * 434 + 200) @(negedge clk);
    check("t6_mid_busy", 32'(mon_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_tx", 32'(mon_tx), 32'd1);
    check("t6_rst_busy", 32'(mon_busy), 32'd0);
    check("t6_rst_done", 32'(mon_done), 32'd0);
    repeat (4500) @(negedge clk);
    check("t6_no_done", dcnt[0] - d0, 32'd0);
    check("t6_idle_tx", 32'(mon_tx), 32'd1);
    data = 32'h0F;
    pulse_send(0);
    check("t6_restart", 32'(mon_tx), 32'd0);
    rx_frame(434, lo, hi, b);
    check("t6_0f_lo", 32'(lo), 32'(frm(8'h0F)));
    check("t6_0f_hi", 32'(hi), 32'(frm(8'h0F)));
    check("t6_done", 32'(mon_done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
